// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder
//   Multi-cycle data-memory responder for the CPU data-side request/ready
//   handshake. Each transaction is a single word read or write. The block
//   inserts WAIT_CYCLES wait states, then pulses ready for one cycle.
//   Addresses at or beyond DEPTH_WORDS*4 are flagged with err. Out-of-range
//   writes are dropped, and out-of-range reads return zero.
//
// Optional build macro: DMEM_BYTE_EN_EN
//   Adds the be[3:0] byte-enable input. Writes then update only the enabled
//   bytes. Without the macro, every write updates the full word.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous active-low reset
//   req    in   1   request strobe, sampled only while idle
//   we     in   1   1 = write, 0 = read, captured with req
//   a      in   32  byte address (a[1:0] ignored)
//   wd     in   32  write data, captured with req
//   be     in   4   byte enables (only with DMEM_BYTE_EN_EN)
//   rd     out  32  read data, valid with ready, held until the next read response
//   ready  out  1   one-cycle completion pulse
//   err    out  1   out-of-range flag, only together with ready
//   busy   out  1   high from acceptance through the ready cycle
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [31:0] a_r;
  logic [31:0] wd_r;
  logic [31:0] rd_r;
  logic        ready_r;
  logic        err_r;
  logic        busy_r;

  logic [31:0] mem_r [DEPTH_WORDS];

  logic        sel_we_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_wd_s;
  logic [3:0]  sel_be_s;
  logic [AW-1:0] idx_s;
  logic        oor_s;
  logic        enter_resp_s;
  logic        wr_en_s;

`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be_r;
  assign sel_be_s = (state_r == ST_IDLE) ? be : be_r;
`else
  assign sel_be_s = 4'b1111;
`endif

  // While idle, use the live inputs so that a zero-wait transaction can respond on its accepting edge.
  always_comb begin
    sel_we_s = we_r;
    sel_a_s  = a_r;
    sel_wd_s = wd_r;
    if (state_r == ST_IDLE) begin
      sel_we_s = we;
      sel_a_s  = a;
      sel_wd_s = wd;
    end else begin
      sel_we_s = we_r;
      sel_a_s  = a_r;
      sel_wd_s = wd_r;
    end
  end

  assign idx_s = sel_a_s[AW+1:2];
  assign oor_s = (sel_a_s >= ADDR_LIMIT);

  // Next-state decode. WAIT always lasts exactly WAIT_CYCLES cycles.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          next_state_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // The response (read data, write commit, ready and err) happens on the edge that enters RESP.
  // This lets the registered outputs and the array update line up with the ready cycle.
  assign enter_resp_s = (next_state_s == ST_RESP);
  // Gating with reset keeps a write from committing while reset is held.
  assign wr_en_s      = enter_resp_s & sel_we_s & ~oor_s & reset;

  // Array write port. Reset deliberately leaves the contents untouched.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= sel_wd_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM: request capture, wait counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      a_r     <= 32'd0;
      wd_r    <= 32'd0;
`ifdef DMEM_BYTE_EN_EN
      be_r    <= 4'd0;
`endif
      rd_r    <= 32'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      ready_r <= enter_resp_s;
      err_r   <= enter_resp_s & oor_s;
      if ((state_r == ST_IDLE) && req) begin
        we_r  <= we;
        a_r   <= a;
        wd_r  <= wd;
`ifdef DMEM_BYTE_EN_EN
        be_r  <= be;
`endif
        cnt_r <= WAIT_INIT;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // A write response leaves rd holding the last read data.
      if (enter_resp_s && !sel_we_s) begin
        rd_r <= oor_s ? 32'd0 : mem_r[idx_s];
      end
    end
  end

  assign rd    = rd_r;
  assign ready = ready_r;
  assign err   = err_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        busy;

  dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .ready (ready),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain word array plus the last value rd is expected to hold.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd_m;

  typedef struct {
    logic        we_v;
    logic [31:0] a_v;
    logic [31:0] wd_v;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Runs one transaction and checks its timing and its result against the model.
  // With inject set, a write request to 0x20 is pulsed while the transaction is busy.
  task automatic txn(input logic t_we, input logic [31:0] t_a, input logic [31:0] t_wd,
                     input bit inject, output logic [31:0] o_rd, output logic o_err);
    int lat;
    int busy_hi;
    int err_extra;
    int after_ready;
    int after_busy;
    bit seen;
    bit oor;
    logic [31:0] exp_rd;
    lat = 0; busy_hi = 0; err_extra = 0; after_ready = 0; after_busy = 0; seen = 0;
    o_rd = 32'hxxxx_xxxx;
    o_err = 1'bx;
    @(negedge clk);
    req = 1'b1; we = t_we; a = t_a; wd = t_wd;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (inject) begin
        if (k == 1) begin
          req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'hBAD0_0BAD;
        end else begin
          req = 1'b0;
        end
      end
      if (busy) busy_hi++;
      if (ready) begin
        seen = 1'b1; lat = k; o_rd = rd; o_err = err;
      end else if (err) begin
        err_extra++;
      end
    end
    req = 1'b0;
    for (int k = 0; k < (inject ? 2*WAITC + 4 : 1); k++) begin
      @(negedge clk);
      if (ready) after_ready++;
      if (busy) after_busy++;
    end
    check("latency", 32'(lat), 32'(WAITC + 1));
    check("busy_cycles", 32'(busy_hi), 32'(WAITC + 1));
    check("err_outside_ready", 32'(err_extra), 32'd0);
    check("idle_after_ready", 32'(after_ready + after_busy), 32'd0);
    oor = (t_a >= 32'(DEPTH * 4));
    if (!t_we) exp_rd = oor ? 32'd0 : mem_m[(t_a >> 2) % DEPTH];
    else       exp_rd = last_rd_m;
    check("rd_model", o_rd, exp_rd);
    check("err_model", {31'd0, o_err}, {31'd0, oor});
    if (t_we && !oor) mem_m[(t_a >> 2) % DEPTH] = t_wd;
    last_rd_m = exp_rd;
  endtask

  logic [31:0] r_rd;
  logic        r_err;
  logic [31:0] ra;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0100, 32'h0000_1234, 1'b0, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hA500_003F, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'hA500_0002, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'hA500_0001, 1'b0};

    reset = 1'b0; req = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    last_rd_m = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_rd", rd, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Load a known pattern into every word.
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 1'b0, r_rd, r_err);
    end

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].we_v, vecs[i].a_v, vecs[i].wd_v, 1'b0, r_rd, r_err);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), r_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'd0, r_err}, {31'd0, vecs[i].exp_err});
    end

    // A request pulsed during WAIT must be dropped.
    txn(1'b0, 32'h4, 32'h0, 1'b1, r_rd, r_err);
    check("inject_main_rd", r_rd, 32'hA500_0001);
    txn(1'b0, 32'h20, 32'h0, 1'b0, r_rd, r_err);
    check("inject_dropped", r_rd, 32'hA500_0008);

    // Reset during WAIT of a write aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h0; wd = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_rd", rd, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rd_m = 32'd0;
    repeat (2) @(negedge clk);
    txn(1'b0, 32'h0, 32'h0, 1'b0, r_rd, r_err);
    check("midrst_old_value", r_rd, 32'hA500_0000);

    // Random traffic checked against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, 300));
      txn(1'($urandom_range(0, 1)), ra, $urandom, 1'b0, r_rd, r_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Multi-cycle data-memory responder serving the CPU's data-side request interface.
- Replaces the zero-latency data RAM when the processor is extended with a request/ready handshake.
- Accepts one word read or write per transaction.
- Inserts a programmable number of wait states, returns read data with a one-cycle ready pulse, and flags out-of-range addresses.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the internal array; power of two, at least 4.
- WAIT_CYCLES, 2: wait states between request acceptance and response; range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  1  request strobe from CPU; sampled only while idle.
- we  input  1  1 = write, 0 = read; captured with req.
- a  input  32  byte address; a[1:0] ignored (word aligned).
- wd  input  32  write data; captured with req.
- rd  output  32  read data; valid in the ready cycle, held until the next response.
- ready  output  1  one-cycle pulse marking transaction completion.
- err  output  1  asserted with ready when the captured address is out of range.
- busy  output  1  high from acceptance through the ready cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; wait counter clears.
  - rd=0, ready=0, err=0, busy=0.
  - Array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, capture we, a, wd into request registers on this edge.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP; busy=1 from the next cycle.
  - If req=0, remain in IDLE.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Go to RESP when the counter is 0.
  - req is ignored; no queueing, dropped silently.
- RESP (exactly one cycle):
  - ready=1.
  - Read: rd = array[index].
  - Write: array[index] <= captured wd on the RESP edge; rd keeps its previous value.
  - Next state is IDLE.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the accepting edge. WAIT_CYCLES=0 gives ready on the cycle after acceptance.
- Back-to-back transactions:
  - A new req may be accepted in the IDLE cycle following RESP.
  - Minimum transaction spacing is WAIT_CYCLES+2 cycles.
- Indexing and range check:
  - index = a[log2(DEPTH_WORDS)+1:2].
  - Out of range when a >= DEPTH_WORDS*4 (unsigned compare on the full 32 bits).
- Out-of-range access:
  - ready=1 and err=1 in RESP.
  - Writes are suppressed.
  - For reads, rd=32'h0000_0000.
  - err=0 in all other cycles.
- Read-after-write: a read accepted after a write's RESP returns the new data.
- Reset asserted mid-transaction: the pending transaction is aborted; a pending write is not committed unless its RESP edge already occurred.
- busy=1 in WAIT and RESP, 0 in IDLE.

Optional Feature:
- DMEM_BYTE_EN_EN defined:
  - Adds input be[3:0], captured with req.
  - On write, only bytes with be[i]=1 are updated (be[0] covers bits 7:0).
  - be=4'b0000 write changes nothing but still produces ready.
  - Reads ignore be.
- Not defined: no be port; every write updates the full 32-bit word.

Test Plan:
- Reset then read: release reset with WAIT_CYCLES=2, read a=0x8 -> rd=0 after reset, ready pulse exactly 3 cycles after acceptance, busy high for 3 cycles.
- Write then read: write a=0x10 wd=0xDEADBEEF, then read a=0x10 -> rd=0xDEADBEEF, err=0; a=0x13 returns the same word.
- Out of range: with DEPTH_WORDS=64, write a=0x100 wd=0x1234 -> ready=1, err=1; read a=0xFC -> previous contents unchanged, err=0; read a=0x100 -> rd=0, err=1.
- Request during busy: pulse req with a=0x20 during WAIT of a transaction to a=0x4 -> only one ready pulse; the a=0x20 request is dropped.
- Reset mid-write: assert reset during WAIT of a write of 0x55 to a=0x0 -> all outputs 0 immediately; subsequent read of a=0x0 returns the old value.
- Byte enable (DMEM_BYTE_EN_EN): word=0x11223344, write wd=0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD.
